// File: rtl/servo_pwm_decoder_pkg.sv
// Shared constants for the servo PWM decoder and the servo driver.
//   - Position codes reported on pos.
//   - Default measurement thresholds in clk cycles (100 MHz).
//   - FSM state encoding.
package servo_pwm_decoder_pkg;

  localparam logic [1:0] POS_I   = 2'd0;
  localparam logic [1:0] POS_C   = 2'd1;
  localparam logic [1:0] POS_D   = 2'd2;
  localparam logic [1:0] POS_BAD = 2'd3;

  localparam int unsigned DEF_CNT_W   = 21;
  localparam int unsigned DEF_TIMEOUT = 2_000_000;
  localparam int unsigned DEF_MIN_W   = 25_000;
  localparam int unsigned DEF_TH_IC   = 100_000;
  localparam int unsigned DEF_TH_CD   = 175_000;
  localparam int unsigned DEF_MAX_W   = 250_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser for the asynchronous PWM input plus edge detection.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   pwm_in    raw asynchronous PWM input
//   s         synchronised level
//   rise      one-cycle pulse on a synchronised 0->1 transition
//   fall      one-cycle pulse on a synchronised 1->0 transition
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  // Synchroniser chain followed by the previous-level register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      s    <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pwm_in;
      s    <= meta;
      prev <= s;
    end
  end

  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures a servo-style PWM input (high time and rising-to-rising period in
// clk cycles), classifies the pulse into a 2-bit position code and flags a
// missing or stuck input.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   pwm_in    asynchronous PWM input
//   width     last measured high time, cycles
//   period    last measured period, cycles
//   pos       position code of the last pulse (POS_I/C/D/BAD)
//   valid     one-cycle strobe when width/period/pos update
//   timeout   sticky: no edge for TIMEOUT cycles; cleared by the next valid
module servo_pwm_decoder
  import servo_pwm_decoder_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned MIN_W   = DEF_MIN_W,
  parameter int unsigned TH_IC   = DEF_TH_IC,
  parameter int unsigned TH_CD   = DEF_TH_CD,
  parameter int unsigned MAX_W   = DEF_MAX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic [1:0]       pos,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] IC_LIM  = CNT_W'(TH_IC);
  localparam logic [CNT_W-1:0] CD_LIM  = CNT_W'(TH_CD);

  logic s, rise, fall;
  logic s_unused;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] w_lat, w_lat_d;
  logic [CNT_W-1:0] width_d, period_d;
  logic [1:0]       pos_d;
  logic             valid_d, timeout_d;
  logic [1:0]       pos_class_c;

  pwm_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  // Edges carry all the timing; the synchronised level is not needed here.
  assign s_unused = s;

  // Classifier: range checks first, then the two position thresholds.
  always_comb begin
    if (w_lat < MIN_LIM) begin
      pos_class_c = POS_BAD;
    end else if (w_lat >= MAX_LIM) begin
      pos_class_c = POS_BAD;
    end else if (w_lat < IC_LIM) begin
      pos_class_c = POS_I;
    end else if (w_lat < CD_LIM) begin
      pos_class_c = POS_C;
    end else begin
      pos_class_c = POS_D;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    w_lat_d   = w_lat;
    width_d   = width;
    period_d  = period;
    pos_d     = pos;
    valid_d   = 1'b0;
    timeout_d = timeout;

    case (state)
      ST_IDLE: begin
        // First rise only arms the measurement.
        if (rise) begin
          cnt_d   = ONE;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          w_lat_d = cnt;
          cnt_d   = cnt + ONE;
          state_d = ST_LOW;
        end else if (cnt >= TO_LIM) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt + ONE;
        end
      end

      ST_LOW: begin
        // A rise closes the period and reports the pulse that just ended.
        if (rise) begin
          period_d  = cnt;
          width_d   = w_lat;
          pos_d     = pos_class_c;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = ONE;
          state_d   = ST_HIGH;
        end else if (cnt >= TO_LIM) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt + ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      w_lat   <= '0;
      width   <= '0;
      period  <= '0;
      pos     <= POS_BAD;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      w_lat   <= w_lat_d;
      width   <= width_d;
      period  <= period_d;
      pos     <= pos_d;
      valid   <= valid_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with thresholds scaled down by 1000.
module tb_servo_pwm_decoder;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic [1:0]       pos;
  logic             valid;
  logic             timeout;

  int n_checks = 0;
  int n_pass   = 0;

  int               vcount = 0;
  int               multi  = 0;
  logic             valid_q = 1'b0;
  logic [CNT_W-1:0] cap_w = '0;
  logic [CNT_W-1:0] cap_p = '0;
  logic [1:0]       cap_pos = 2'd0;
  logic             cap_to = 1'b0;

  int tab_w   [12] = '{1, 24, 25, 99, 100, 174, 175, 249, 250, 60, 140, 230};
  int tab_pos [12] = '{3,  3,  0,  0,   1,   1,   2,   2,   3,  0,   1,   2};

  servo_pwm_decoder #(
    .CNT_W   (CNT_W),
    .TIMEOUT (2000),
    .MIN_W   (25),
    .TH_IC   (100),
    .TH_CD   (175),
    .MAX_W   (250)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .width   (width),
    .period  (period),
    .pos     (pos),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every report and flag strobes longer than one cycle.
  always @(negedge clk) begin
    valid_q <= valid;
    if (valid) begin
      vcount  <= vcount + 1;
      cap_w   <= width;
      cap_p   <= period;
      cap_pos <= pos;
      cap_to  <= timeout;
      if (valid_q) multi <= multi + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // One PWM period: high for hi cycles, low for the remainder. Called at negedge.
  task automatic pulse(input int hi, input int per);
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  int v0;

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_width",   32'(width),   0);
    check("rst_period",  32'(period),  0);
    check("rst_pos",     32'(pos),     3);
    check("rst_valid",   32'(valid),   0);
    check("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Three identical periods give two reports.
    repeat (3) pulse(50, 1000);
    check("t1_count",  vcount, 2);
    check("t1_width",  32'(cap_w), 50);
    check("t1_period", 32'(cap_p), 1000);
    check("t1_pos",    32'(cap_pos), 0);

    // Centre then right, each reported at the next rise.
    pulse(150, 1000);
    pulse(200, 1000);
    check("t2_width_c", 32'(cap_w), 150);
    check("t2_pos_c",   32'(cap_pos), 1);
    pulse(10, 1000);
    check("t2_width_d", 32'(cap_w), 200);
    check("t2_pos_d",   32'(cap_pos), 2);
    check("t2_timeout", 32'(timeout), 0);

    // Too short, then too long: still reported with pos 3.
    pulse(300, 1000);
    check("t3_width_short", 32'(cap_w), 10);
    check("t3_pos_short",   32'(cap_pos), 3);

    // Stuck high: the rise reports the 300 pulse, then timeout fires.
    v0 = vcount;
    pwm_in = 1'b1;
    repeat (2001) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    check("t3_width_long", 32'(cap_w), 300);
    check("t3_pos_long",   32'(cap_pos), 3);
    check("t4_one_report", vcount, v0 + 1);
    check("t4_timeout",    32'(timeout), 1);
    check("t4_hold_width", 32'(width), 300);
    check("t4_hold_period", 32'(period), 1000);
    check("t4_hold_pos",   32'(pos), 3);
    pulse(150, 1000);
    check("t4_arm_no_valid", vcount, v0 + 1);
    check("t4_timeout_sticky", 32'(timeout), 1);
    pulse(150, 1000);
    check("t4_timeout_clr", 32'(timeout), 0);
    check("t4_cap_to",      32'(cap_to), 0);
    check("t4_width",       32'(cap_w), 150);
    check("t4_pos",         32'(cap_pos), 1);

    // Reset in the middle of a high phase.
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_width",   32'(width),   0);
    check("t5_period",  32'(period),  0);
    check("t5_pos",     32'(pos),     3);
    check("t5_valid",   32'(valid),   0);
    check("t5_timeout", 32'(timeout), 0);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    v0 = vcount;
    pulse(60, 500);
    check("t5_arm_no_valid", vcount, v0);
    pulse(60, 500);
    check("t5_first_valid", vcount, v0 + 1);
    check("t5_width_new",   32'(cap_w), 60);
    check("t5_period_new",  32'(cap_p), 500);

    // Glitches, threshold boundaries and loop-back position codes.
    for (int i = 0; i < 12; i++) begin
      pulse(tab_w[i], 500);
      if (i > 0) begin
        check($sformatf("t6_width_%0d", tab_w[i-1]), 32'(cap_w), 32'(tab_w[i-1]));
        check($sformatf("t6_pos_%0d",   tab_w[i-1]), 32'(cap_pos), 32'(tab_pos[i-1]));
      end
    end
    pulse(1, 500);
    check("t6_width_last", 32'(cap_w), 230);
    check("t6_pos_last",   32'(cap_pos), 2);
    check("t6_period",     32'(cap_p), 500);

    check("strobe_one_cycle", multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
